mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_sequencer_if.sv | 28 ++
 rtl/mac_sequencer.sv | 143 ++++++++++++++
 tb/tb_mac_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Control/data bundle between the 4x4 matrix-multiply sequencer and its
// MAC datapath plus the A/B operand and C result memories.
interface mac_sequencer_if;
  logic       start;
  logic       abort;
  logic [9:0] acc_in;
  logic       busy;
  logic       done;
  logic [3:0] a_addr;
  logic [3:0] b_addr;
  logic       mac_clear;
  logic       mac_ld;
  logic [3:0] c_addr;
  logic       c_we;
  logic [9:0] c_data;

  // Sequencer side: takes commands and the accumulator, drives addresses/strobes.
  modport master (
    input  start, abort, acc_in,
    output busy, done, a_addr, b_addr, mac_clear, mac_ld, c_addr, c_we, c_data
  );

  // Datapath/host side: the mirror image of master.
  modport slave (
    output start, abort, acc_in,
    input  busy, done, a_addr, b_addr, mac_clear, mac_ld, c_addr, c_we, c_data
  );
endinterface

// File: rtl/mac_sequencer.sv
// Sequencer for C = A x B on fixed 4x4 matrices of 4-bit elements.
// Per C element: one CLR cycle, four MAC cycles (k = 0..3), one WB cycle.
// All outputs are Moore decodes of state and counters; the only
// combinational input-to-output path is acc_in -> c_data during WB.
module mac_sequencer (
  input  logic           clk,
  input  logic           reset,
  mac_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_MAC  = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] i_q;
  logic [1:0] j_q;
  logic [1:0] k_q;
  logic [1:0] i_d;
  logic [1:0] j_d;
  logic [1:0] k_d;
  logic       last_elem;

  assign last_elem = (i_q == 2'd3) && (j_q == 2'd3);

  // State and loop-counter registers; reset overrides start and abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= 2'd0;
      j_q     <= 2'd0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // Next-state and counter sequencing; abort in any busy state wins over every transition.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        // abort is deliberately not looked at here, so start always wins in IDLE
        if (bus.start) begin
          state_d = S_CLR;
          i_d     = 2'd0;
          j_d     = 2'd0;
          k_d     = 2'd0;
        end
      end
      S_CLR: begin
        k_d     = 2'd0;
        state_d = S_MAC;
      end
      S_MAC: begin
        // k wraps 3 -> 0 naturally on the last product
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (last_elem) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + 2'd1;
          if (j_q == 2'd3) begin
            i_d = i_q + 2'd1;
          end
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        // start is not sampled here; a held start is picked up from IDLE
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q != S_IDLE) && bus.abort) begin
      state_d = S_IDLE;
      i_d     = 2'd0;
      j_d     = 2'd0;
      k_d     = 2'd0;
    end
  end

  // Moore output decode; addresses and strobes are zero outside their owning state.
  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mac_clear = 1'b0;
    bus.mac_ld    = 1'b0;
    bus.a_addr    = 4'd0;
    bus.b_addr    = 4'd0;
    bus.c_addr    = 4'd0;
    bus.c_we      = 1'b0;
    bus.c_data    = 10'd0;
    unique case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
      end
      S_CLR: begin
        bus.busy      = 1'b1;
        bus.mac_clear = 1'b1;
      end
      S_MAC: begin
        bus.busy   = 1'b1;
        bus.mac_ld = 1'b1;
        bus.a_addr = {i_q, k_q};
        bus.b_addr = {k_q, j_q};
      end
      S_WB: begin
        // a 4-term dot product of 4-bit values peaks at 900, so 10 bits never truncate
        bus.busy   = 1'b1;
        bus.c_we   = 1'b1;
        bus.c_addr = {i_q, j_q};
        bus.c_data = bus.acc_in;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: models the MAC datapath and A/B memories around
// the sequencer and scores every C write against an independent reference.
`timescale 1ns/1ps
module tb_mac_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_sequencer_if bus();

  mac_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] addr;
    logic [9:0] data;
    int         cyc;
  } wr_t;

  logic [3:0] mat_a [16];
  logic [3:0] mat_b [16];
  logic [9:0] acc = 10'd0;
  wr_t        exp_q [$];

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int t_start  = 0;
  int done_cnt = 0;
  int done_rel = -1;
  int wr_cnt   = 0;

  // Datapath model: clear or accumulate the addressed product.
  always @(posedge clk) begin
    if (bus.mac_clear) acc <= 10'd0;
    else if (bus.mac_ld) acc <= acc + (10'(mat_a[bus.a_addr]) * 10'(mat_b[bus.b_addr]));
  end
  assign bus.acc_in = acc;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard for C writes, done timing and protocol invariants.
  always @(negedge clk) begin : mon
    int  rel;
    wr_t e;
    int  ld_run;
    bit  clr_seen;
    rel = cyc - t_start;
    checks++;
    if (bus.mac_clear === 1'b1 && bus.mac_ld === 1'b1) begin
      errors++; $display("FAIL clr_ld_overlap: cycle %0d got both high, required exclusive", rel);
    end
    checks++;
    if (bus.mac_ld !== 1'b1 && (bus.a_addr !== 4'd0 || bus.b_addr !== 4'd0)) begin
      errors++; $display("FAIL addr_idle: cycle %0d got a=%0d b=%0d, required 0", rel, bus.a_addr, bus.b_addr);
    end
    checks++;
    if (bus.c_we !== 1'b1 && (bus.c_addr !== 4'd0 || bus.c_data !== 10'd0)) begin
      errors++; $display("FAIL c_idle: cycle %0d got addr=%0d data=%0d, required 0", rel, bus.c_addr, bus.c_data);
    end
    if (bus.busy !== 1'b1) begin
      ld_run = 0; clr_seen = 0;
    end
    if (bus.mac_clear === 1'b1) begin
      checks++;
      if (ld_run != 0) begin
        errors++; $display("FAIL clr_group: cycle %0d got %0d loads before clear, required 0", rel, ld_run);
      end
      clr_seen = 1;
    end
    if (bus.mac_ld === 1'b1) begin
      checks++;
      if (!clr_seen || ld_run >= 4) begin
        errors++; $display("FAIL ld_group: cycle %0d got clr_seen=%0d loads=%0d, required clear and <4", rel, clr_seen, ld_run);
      end
      ld_run++;
    end
    if (bus.c_we === 1'b1) begin
      wr_cnt++;
      checks++;
      if (ld_run != 4) begin
        errors++; $display("FAIL wb_group: cycle %0d got %0d loads before write, required 4", rel, ld_run);
      end
      ld_run = 0; clr_seen = 0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_write: cycle %0d got addr=%0d data=%0d, required no write", rel, bus.c_addr, bus.c_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.c_addr !== e.addr || bus.c_data !== e.data || rel != e.cyc) begin
          errors++;
          $display("FAIL c_write: got addr=%0d data=%0d cycle=%0d, required addr=%0d data=%0d cycle=%0d",
                   bus.c_addr, bus.c_data, rel, e.addr, e.data, e.cyc);
        end
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_rel = rel;
    end
  end

  function automatic logic [9:0] c_exp(int i, int j);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'(mat_a[i*4+k]) * int'(mat_b[k*4+j]);
    return 10'(s);
  endfunction

  task automatic push_elems(int first, int last);
    wr_t e;
    for (int n = first; n <= last; n++) begin
      e.addr = 4'(n);
      e.data = c_exp(n / 4, n % 4);
      e.cyc  = 6 * n + 6;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_random();
    for (int x = 0; x < 16; x++) begin
      mat_a[x] = 4'($urandom_range(0, 15));
      mat_b[x] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    t_start   = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_rel(int r);
    while ((cyc - t_start) < r) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b1; bus.abort = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", bus.done); end
    checks++; if (bus.mac_clear !== 1'b0) begin errors++; $display("FAIL rst_clear: got %b required 0", bus.mac_clear); end
    checks++; if (bus.mac_ld !== 1'b0) begin errors++; $display("FAIL rst_ld: got %b required 0", bus.mac_ld); end
    checks++; if (bus.c_we !== 1'b0) begin errors++; $display("FAIL rst_cwe: got %b required 0", bus.c_we); end
    checks++; if (bus.a_addr !== 4'd0 || bus.b_addr !== 4'd0 || bus.c_addr !== 4'd0) begin
      errors++; $display("FAIL rst_addr: got a=%0d b=%0d c=%0d required 0", bus.a_addr, bus.b_addr, bus.c_addr); end
    checks++; if (bus.c_data !== 10'd0) begin errors++; $display("FAIL rst_cdata: got %0d required 0", bus.c_data); end
    reset = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_all15();
    int d0, w0;
    for (int x = 0; x < 16; x++) begin mat_a[x] = 4'd15; mat_b[x] = 4'd15; end
    d0 = done_cnt; w0 = wr_cnt;
    push_elems(0, 15);
    checks++; if (exp_q[0].data !== 10'd900) begin errors++; $display("FAIL ref_900: got %0d required 900", exp_q[0].data); end
    pulse_start();
    checks++; if (bus.busy !== 1'b1 || bus.mac_clear !== 1'b1) begin
      errors++; $display("FAIL all15_c1: got busy=%b clear=%b required 1 1", bus.busy, bus.mac_clear); end
    wait_rel(97);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL all15_c97: got done=%b busy=%b required 1 1", bus.done, bus.busy); end
    wait_rel(98);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL all15_c98: got busy=%b done=%b required 0 0", bus.busy, bus.done); end
    checks++; if (done_cnt - d0 != 1 || done_rel != 97) begin
      errors++; $display("FAIL all15_done: got count=%0d cycle=%0d required 1 at 97", done_cnt - d0, done_rel); end
    checks++; if (wr_cnt - w0 != 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL all15_writes: got %0d left=%0d required 16 left=0", wr_cnt - w0, exp_q.size()); end
  endtask

  task automatic test_identity();
    int w0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a[r*4+c] = (r == c) ? 4'd1 : 4'd0;
        mat_b[r*4+c] = 4'(4*r + c);
      end
    w0 = wr_cnt;
    push_elems(0, 15);
    pulse_start();
    wait_rel(30);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_rel(38 + k);
      checks++;
      if (bus.mac_ld !== 1'b1 || bus.a_addr !== 4'(4 + k) || bus.b_addr !== 4'(2 + 4*k)) begin
        errors++; $display("FAIL id_addr k=%0d: got ld=%b a=%0d b=%0d required 1 %0d %0d",
                           k, bus.mac_ld, bus.a_addr, bus.b_addr, 4 + k, 2 + 4*k);
      end
    end
    wait_rel(98);
    checks++; if (done_rel != 97 || wr_cnt - w0 != 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL id_run: got done=%0d writes=%0d left=%0d required 97 16 0",
                         done_rel, wr_cnt - w0, exp_q.size()); end
  endtask

  task automatic test_hold_start();
    int d0;
    set_random();
    d0 = done_cnt;
    push_elems(0, 15);
    @(negedge clk);
    bus.start = 1'b1;
    t_start   = cyc;
    wait_rel(97);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL hold_done: got %b required 1", bus.done); end
    wait_rel(98);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_idle98: got busy=%b required 0", bus.busy); end
    wait_rel(99);
    checks++; if (bus.busy !== 1'b1 || bus.mac_clear !== 1'b1) begin
      errors++; $display("FAIL hold_clr99: got busy=%b clear=%b required 1 1", bus.busy, bus.mac_clear); end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    wait_rel(100);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_abort: got busy=%b required 0", bus.busy); end
    bus.abort = 1'b0;
    wait_rel(110);
    checks++; if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL hold_run: got done=%0d left=%0d required 1 0", done_cnt - d0, exp_q.size()); end
  endtask

  task automatic test_abort_mac();
    int d0, w0;
    set_random();
    d0 = done_cnt; w0 = wr_cnt;
    push_elems(0, 2);
    pulse_start();
    wait_rel(20);
    bus.abort = 1'b1;
    wait_rel(21);
    checks++; if (bus.busy !== 1'b0 || bus.mac_ld !== 1'b0) begin
      errors++; $display("FAIL abort_c21: got busy=%b ld=%b required 0 0", bus.busy, bus.mac_ld); end
    bus.abort = 1'b0;
    wait_rel(110);
    checks++; if (done_cnt != d0 || wr_cnt - w0 != 3 || exp_q.size() != 0) begin
      errors++; $display("FAIL abort_run: got done=%0d writes=%0d left=%0d required 0 3 0",
                         done_cnt - d0, wr_cnt - w0, exp_q.size()); end
  endtask

  task automatic test_abort_wb();
    int w0;
    set_random();
    w0 = wr_cnt;
    push_elems(0, 0);
    pulse_start();
    wait_rel(6);
    checks++; if (bus.c_we !== 1'b1) begin errors++; $display("FAIL abort_wb_we: got %b required 1", bus.c_we); end
    bus.abort = 1'b1;
    wait_rel(7);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_wb_idle: got busy=%b required 0", bus.busy); end
    bus.abort = 1'b0;
    wait_rel(20);
    checks++; if (wr_cnt - w0 != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL abort_wb_run: got writes=%0d left=%0d required 1 0", wr_cnt - w0, exp_q.size()); end
  endtask

  task automatic test_abort_start_idle();
    bus.abort = 1'b1;
    pulse_start();
    checks++; if (bus.busy !== 1'b1 || bus.mac_clear !== 1'b1) begin
      errors++; $display("FAIL idle_start_wins: got busy=%b clear=%b required 1 1", bus.busy, bus.mac_clear); end
    wait_rel(2);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_then_abort: got busy=%b required 0", bus.busy); end
    bus.abort = 1'b0;
    wait_rel(5);
  endtask

  task automatic test_reset_midrun();
    int d0, w0;
    set_random();
    d0 = done_cnt; w0 = wr_cnt;
    push_elems(0, 5);
    pulse_start();
    wait_rel(40);
    reset = 1'b1;
    wait_rel(41);
    checks++; if (bus.busy !== 1'b0 || bus.mac_ld !== 1'b0 || bus.mac_clear !== 1'b0 || bus.c_we !== 1'b0 ||
                  bus.done !== 1'b0 || bus.a_addr !== 4'd0 || bus.b_addr !== 4'd0) begin
      errors++; $display("FAIL midrst_c41: got busy=%b ld=%b clr=%b we=%b done=%b a=%0d b=%0d required all 0",
                         bus.busy, bus.mac_ld, bus.mac_clear, bus.c_we, bus.done, bus.a_addr, bus.b_addr); end
    reset = 1'b0;
    wait_rel(60);
    checks++; if (done_cnt != d0 || wr_cnt - w0 != 6 || exp_q.size() != 0) begin
      errors++; $display("FAIL midrst_cut: got done=%0d writes=%0d left=%0d required 0 6 0",
                         done_cnt - d0, wr_cnt - w0, exp_q.size()); end
    set_random();
    w0 = wr_cnt;
    push_elems(0, 15);
    pulse_start();
    wait_rel(98);
    checks++; if (done_cnt - d0 != 1 || done_rel != 97 || wr_cnt - w0 != 16 || exp_q.size() != 0) begin
      errors++; $display("FAIL midrst_restart: got done=%0d at %0d writes=%0d left=%0d required 1 at 97 16 0",
                         done_cnt - d0, done_rel, wr_cnt - w0, exp_q.size()); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    reset     = 1'b1;
    for (int x = 0; x < 16; x++) begin mat_a[x] = 4'd0; mat_b[x] = 4'd0; end
    test_reset();
    test_all15();
    test_identity();
    test_hold_start();
    test_abort_mac();
    test_abort_wb();
    test_abort_start_idle();
    test_reset_midrun();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
